// File: rtl/mem_arbiter.sv
// Two-port arbiter (instruction fetch / load-store) in front of mem_control.
// Sequences the two-cycle access protocol and answers misaligned requests locally.
module mem_arbiter #(
  parameter int DATA_PRIORITY = 0
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [1:0]  d_acc_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  output logic [1:0]  mem_acc_r_o,
  output logic [31:0] mem_addr_r_o,
  input  logic [31:0] mem_data_r_i,
  output logic        mem_wr_en_o,
  output logic [1:0]  mem_acc_w_o,
  output logic [31:0] mem_addr_w_o,
  output logic [31:0] mem_data_w_o,
  input  logic        mem_wr_ready_i
);

  localparam logic [1:0] MEM_ACCESS_BYTE     = 2'b00;
  localparam logic [1:0] MEM_ACCESS_HALFWORD = 2'b01;
  localparam logic [1:0] MEM_ACCESS_WORD     = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RD_RESP  = 2'b01,
    ST_WR_PEND  = 2'b10,
    ST_ERR_RESP = 2'b11
  } state_t;

  state_t      state, state_nxt;
  logic        prio_d;
  logic        lat_port;  // 1 = data port owns the in-flight access
  logic        lat_we;
  logic [1:0]  lat_acc;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic        grant;
  logic        pick_d;
  logic        win_we;
  logic [1:0]  win_acc;
  logic [31:0] win_addr;
  logic        win_mis;

  function automatic logic misaligned(input logic is_d, input logic [1:0] acc,
                                      input logic [1:0] lsb);
    if (!is_d) return lsb != 2'b00;
    case (acc)
      MEM_ACCESS_BYTE:     return 1'b0;
      MEM_ACCESS_HALFWORD: return lsb[0];
      default:             return lsb != 2'b00;
    endcase
  endfunction

  // A lone request always wins; ties go to data (fixed) or to prio_d (round-robin).
  assign pick_d   = (DATA_PRIORITY != 0) ? d_req_i : (d_req_i && (!if_req_i || prio_d));
  assign win_we   = pick_d & d_we_i;
  assign win_acc  = pick_d ? d_acc_i : MEM_ACCESS_WORD;
  assign win_addr = pick_d ? d_addr_i : if_addr_i;
  assign win_mis  = misaligned(pick_d, win_acc, win_addr[1:0]);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= ST_IDLE;
      prio_d    <= 1'b1;
      lat_port  <= 1'b0;
      lat_we    <= 1'b0;
      lat_acc   <= 2'b00;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        prio_d    <= ~pick_d;
        lat_port  <= pick_d;
        lat_we    <= win_we;
        lat_acc   <= win_acc;
        lat_addr  <= win_addr;
        lat_wdata <= d_wdata_i;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    grant        = 1'b0;
    if_gnt_o     = 1'b0;
    if_rvalid_o  = 1'b0;
    if_rdata_o   = 32'h0;
    if_err_o     = 1'b0;
    d_gnt_o      = 1'b0;
    d_rvalid_o   = 1'b0;
    d_rdata_o    = 32'h0;
    d_err_o      = 1'b0;
    mem_acc_r_o  = 2'b00;
    mem_addr_r_o = 32'h0;
    mem_wr_en_o  = 1'b0;
    mem_acc_w_o  = 2'b00;
    mem_addr_w_o = 32'h0;
    mem_data_w_o = 32'h0;
    case (state)
      ST_IDLE: begin
        // rstn_i gates the grant so nothing is accepted while reset is held.
        grant = rstn_i && mem_wr_ready_i && (if_req_i || d_req_i);
        if (grant) begin
          d_gnt_o  = pick_d;
          if_gnt_o = ~pick_d;
          if (win_mis) begin
            state_nxt = ST_ERR_RESP;
          end else if (win_we) begin
            mem_wr_en_o  = 1'b1;
            mem_acc_w_o  = win_acc;
            mem_addr_w_o = win_addr;
            mem_data_w_o = d_wdata_i;
            state_nxt    = ST_WR_PEND;
          end else begin
            mem_acc_r_o  = win_acc;
            mem_addr_r_o = win_addr;
            state_nxt    = ST_RD_RESP;
          end
        end
      end
      ST_RD_RESP: begin
        mem_acc_r_o  = lat_acc;
        mem_addr_r_o = lat_addr;
        if (lat_port) begin
          d_rvalid_o = 1'b1;
          d_rdata_o  = mem_data_r_i;
        end else begin
          if_rvalid_o = 1'b1;
          if_rdata_o  = mem_data_r_i;
        end
        state_nxt = ST_IDLE;
      end
      ST_WR_PEND: begin
        mem_acc_w_o  = lat_acc;
        mem_addr_w_o = lat_addr;
        mem_data_w_o = lat_wdata;
        d_rvalid_o   = lat_we;
        state_nxt    = ST_IDLE;
      end
      ST_ERR_RESP: begin
        if (lat_port) begin
          d_rvalid_o = 1'b1;
          d_err_o    = 1'b1;
        end else begin
          if_rvalid_o = 1'b1;
          if_err_o    = 1'b1;
        end
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance and a fixed-priority
// instance share the same stimulus.
module tb_mem_arbiter;

  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] WORD = 2'b10;

  logic        clk = 1'b0;
  logic        rstn;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req, d_we;
  logic [1:0]  d_acc;
  logic [31:0] d_addr, d_wdata;
  logic [31:0] mem_data_r;
  logic        mem_wr_ready;

  logic        if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err;
  logic [31:0] if_rdata, d_rdata, mem_addr_r, mem_addr_w, mem_data_w;
  logic [1:0]  mem_acc_r, mem_acc_w;
  logic        mem_wr_en;

  logic        p1_if_gnt, p1_if_rvalid, p1_if_err, p1_d_gnt, p1_d_rvalid, p1_d_err;
  logic [31:0] p1_if_rdata, p1_d_rdata, p1_mem_addr_r, p1_mem_addr_w, p1_mem_data_w;
  logic [1:0]  p1_mem_acc_r, p1_mem_acc_w;
  logic        p1_mem_wr_en;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_PRIORITY(0)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_err_o(if_err),
    .d_req_i(d_req), .d_we_i(d_we), .d_acc_i(d_acc), .d_addr_i(d_addr),
    .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid),
    .d_rdata_o(d_rdata), .d_err_o(d_err),
    .mem_acc_r_o(mem_acc_r), .mem_addr_r_o(mem_addr_r), .mem_data_r_i(mem_data_r),
    .mem_wr_en_o(mem_wr_en), .mem_acc_w_o(mem_acc_w), .mem_addr_w_o(mem_addr_w),
    .mem_data_w_o(mem_data_w), .mem_wr_ready_i(mem_wr_ready)
  );

  mem_arbiter #(.DATA_PRIORITY(1)) dut_fixed (
    .clk_i(clk), .rstn_i(rstn),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(p1_if_gnt),
    .if_rvalid_o(p1_if_rvalid), .if_rdata_o(p1_if_rdata), .if_err_o(p1_if_err),
    .d_req_i(d_req), .d_we_i(d_we), .d_acc_i(d_acc), .d_addr_i(d_addr),
    .d_wdata_i(d_wdata), .d_gnt_o(p1_d_gnt), .d_rvalid_o(p1_d_rvalid),
    .d_rdata_o(p1_d_rdata), .d_err_o(p1_d_err),
    .mem_acc_r_o(p1_mem_acc_r), .mem_addr_r_o(p1_mem_addr_r), .mem_data_r_i(mem_data_r),
    .mem_wr_en_o(p1_mem_wr_en), .mem_acc_w_o(p1_mem_acc_w), .mem_addr_w_o(p1_mem_addr_w),
    .mem_data_w_o(p1_mem_data_w), .mem_wr_ready_i(mem_wr_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; mem_wr_ready = 1'b1;
    if_req = 1'b1; if_addr = 32'h0000_0500;
    d_req = 1'b1; d_we = 1'b0; d_acc = WORD; d_addr = 32'h0000_0040; d_wdata = 32'h0;
    mem_data_r = 32'h1122_3344;
    step(); step(); mid();
    checks++; if ({if_gnt, d_gnt} !== 2'b00) begin fails++; $display("FAIL rst_gnt got %b required 00", {if_gnt, d_gnt}); end
    checks++; if ({if_rvalid, d_rvalid, if_err, d_err, mem_wr_en} !== 5'b0) begin fails++; $display("FAIL rst_flags got %b required 0", {if_rvalid, d_rvalid, if_err, d_err, mem_wr_en}); end
    checks++; if ((if_rdata | d_rdata | mem_addr_r | mem_addr_w | mem_data_w) !== 32'h0) begin fails++; $display("FAIL rst_buses got nonzero required 0"); end
    checks++; if ({mem_acc_r, mem_acc_w} !== 4'b0) begin fails++; $display("FAIL rst_acc got %b required 0", {mem_acc_r, mem_acc_w}); end
    step(); rstn = 1'b1; mem_wr_ready = 1'b0; mid();
    checks++; if ({if_gnt, d_gnt, p1_if_gnt, p1_d_gnt} !== 4'b0) begin fails++; $display("FAIL notready_gnt got %b required 0000", {if_gnt, d_gnt, p1_if_gnt, p1_d_gnt}); end
    step(); mem_wr_ready = 1'b1; mid();
    checks++; if ({if_gnt, d_gnt} !== 2'b01) begin fails++; $display("FAIL first_gnt got %b required 01", {if_gnt, d_gnt}); end
    checks++; if ({p1_if_gnt, p1_d_gnt} !== 2'b01) begin fails++; $display("FAIL first_gnt_fixed got %b required 01", {p1_if_gnt, p1_d_gnt}); end
    checks++; if (mem_addr_r !== 32'h40 || mem_acc_r !== WORD) begin fails++; $display("FAIL first_rd_addr got %h/%b required 40/%b", mem_addr_r, mem_acc_r, WORD); end
    step(); if_req = 1'b0; d_req = 1'b0; mid();
    checks++; if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'h1122_3344}) begin fails++; $display("FAIL first_resp got %b%b %h required 10 11223344", d_rvalid, d_err, d_rdata); end
    step();
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h0000_0100; mem_data_r = 32'hDEAD_BEEF; mid();
    checks++; if ({if_gnt, d_gnt} !== 2'b10) begin fails++; $display("FAIL fetch_gnt got %b required 10", {if_gnt, d_gnt}); end
    checks++; if (mem_addr_r !== 32'h100 || mem_acc_r !== WORD || mem_wr_en !== 1'b0) begin fails++; $display("FAIL fetch_rd_n got %h/%b/%b required 100/%b/0", mem_addr_r, mem_acc_r, mem_wr_en, WORD); end
    step(); if_req = 1'b0; if_addr = 32'h0; mid();
    checks++; if (mem_addr_r !== 32'h100) begin fails++; $display("FAIL fetch_rd_n1 got %h required 100", mem_addr_r); end
    checks++; if ({if_rvalid, if_err, if_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin fails++; $display("FAIL fetch_resp got %b%b %h required 10 deadbeef", if_rvalid, if_err, if_rdata); end
    checks++; if ({if_gnt, d_gnt, d_rvalid} !== 3'b000) begin fails++; $display("FAIL fetch_resp_quiet got %b required 000", {if_gnt, d_gnt, d_rvalid}); end
    step();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rr, exp_fix;
    if_req = 1'b1; if_addr = 32'h400;
    d_req = 1'b1; d_we = 1'b0; d_acc = WORD; d_addr = 32'h300;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      if (k == 7) begin if_req = 1'b0; d_req = 1'b0; end
      mid();
      // round-robin order D, IF, D, IF on even cycles; fixed priority D every time
      if (k % 2 == 1) exp_rr = 4'b0000;
      else exp_rr = (k % 4 == 0) ? 4'b0100 : 4'b1000;
      exp_fix = (k % 2 == 0) ? 4'b0100 : 4'b0000;
      checks++; if ({if_gnt, d_gnt, 2'b00} !== exp_rr) begin fails++; $display("FAIL rr_gnt[%0d] got %b required %b", k, {if_gnt, d_gnt}, exp_rr[3:2]); end
      checks++; if ({p1_if_gnt, p1_d_gnt, 2'b00} !== exp_fix) begin fails++; $display("FAIL fixed_gnt[%0d] got %b required %b", k, {p1_if_gnt, p1_d_gnt}, exp_fix[3:2]); end
    end
    step();
  endtask

  task automatic test_store();
    d_req = 1'b1; d_we = 1'b1; d_acc = BYTE; d_addr = 32'h203; d_wdata = 32'hAB; mid();
    checks++; if (d_gnt !== 1'b1 || mem_wr_en !== 1'b1) begin fails++; $display("FAIL st_gnt got %b%b required 11", d_gnt, mem_wr_en); end
    checks++; if (mem_addr_w !== 32'h203 || mem_acc_w !== BYTE || mem_data_w !== 32'hAB) begin fails++; $display("FAIL st_wr_n got %h/%b/%h required 203/00/ab", mem_addr_w, mem_acc_w, mem_data_w); end
    checks++; if (mem_addr_r !== 32'h0) begin fails++; $display("FAIL st_rd_quiet got %h required 0", mem_addr_r); end
    step(); d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; mid();
    checks++; if (mem_wr_en !== 1'b0 || mem_addr_w !== 32'h203 || mem_acc_w !== BYTE || mem_data_w !== 32'hAB) begin fails++; $display("FAIL st_hold got %b %h/%b/%h required 0 203/00/ab", mem_wr_en, mem_addr_w, mem_acc_w, mem_data_w); end
    checks++; if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'h0}) begin fails++; $display("FAIL st_resp got %b%b %h required 10 0", d_rvalid, d_err, d_rdata); end
    step(); mid();
    checks++; if ({mem_wr_en, d_rvalid, mem_addr_w} !== {2'b00, 32'h0}) begin fails++; $display("FAIL st_after got %b%b %h required 00 0", mem_wr_en, d_rvalid, mem_addr_w); end
    step();
  endtask

  task automatic test_misaligned();
    mem_data_r = 32'hFFFF_8001;
    d_req = 1'b1; d_we = 1'b0; d_acc = WORD; d_addr = 32'h102; mid();
    checks++; if (d_gnt !== 1'b1 || mem_addr_r !== 32'h0 || mem_wr_en !== 1'b0) begin fails++; $display("FAIL mis_w_gnt got %b %h %b required 1 0 0", d_gnt, mem_addr_r, mem_wr_en); end
    step(); d_req = 1'b0; mid();
    checks++; if ({d_rvalid, d_err, d_rdata} !== {2'b11, 32'h0}) begin fails++; $display("FAIL mis_w_resp got %b%b %h required 11 0", d_rvalid, d_err, d_rdata); end
    step();
    d_req = 1'b1; d_acc = HALF; d_addr = 32'h102; mid();
    checks++; if (d_gnt !== 1'b1 || mem_addr_r !== 32'h102 || mem_acc_r !== HALF) begin fails++; $display("FAIL half_gnt got %b %h/%b required 1 102/01", d_gnt, mem_addr_r, mem_acc_r); end
    step(); d_req = 1'b0; mid();
    checks++; if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'hFFFF_8001}) begin fails++; $display("FAIL half_resp got %b%b %h required 10 ffff8001", d_rvalid, d_err, d_rdata); end
    step();
    d_req = 1'b1; d_acc = HALF; d_addr = 32'h103; mid();
    checks++; if (d_gnt !== 1'b1 || mem_addr_r !== 32'h0) begin fails++; $display("FAIL mis_h_gnt got %b %h required 1 0", d_gnt, mem_addr_r); end
    step(); d_req = 1'b0; mid();
    checks++; if ({d_rvalid, d_err} !== 2'b11) begin fails++; $display("FAIL mis_h_resp got %b required 11", {d_rvalid, d_err}); end
    step();
    if_req = 1'b1; if_addr = 32'h101; mid();
    checks++; if (if_gnt !== 1'b1 || mem_addr_r !== 32'h0) begin fails++; $display("FAIL mis_if_gnt got %b %h required 1 0", if_gnt, mem_addr_r); end
    step(); if_req = 1'b0; mid();
    checks++; if ({if_rvalid, if_err, if_rdata, d_rvalid} !== {2'b11, 32'h0, 1'b0}) begin fails++; $display("FAIL mis_if_resp got %b%b %h %b required 11 0 0", if_rvalid, if_err, if_rdata, d_rvalid); end
    step();
  endtask

  task automatic test_reset_mid_store();
    d_req = 1'b1; d_we = 1'b1; d_acc = WORD; d_addr = 32'h80; d_wdata = 32'h5555_AAAA; mid();
    checks++; if (mem_wr_en !== 1'b1 || mem_addr_w !== 32'h80) begin fails++; $display("FAIL rs_gnt got %b %h required 1 80", mem_wr_en, mem_addr_w); end
    step(); d_req = 1'b0; d_we = 1'b0; rstn = 1'b0; #1;
    checks++; if ({d_rvalid, d_err, mem_wr_en, d_gnt, if_gnt} !== 5'b0) begin fails++; $display("FAIL rs_flags got %b required 0", {d_rvalid, d_err, mem_wr_en, d_gnt, if_gnt}); end
    checks++; if ((mem_addr_w | mem_data_w | d_rdata | mem_addr_r) !== 32'h0 || mem_acc_w !== 2'b00) begin fails++; $display("FAIL rs_buses got %h/%h required 0", mem_addr_w, mem_data_w); end
    step(); rstn = 1'b1; mem_wr_ready = 1'b0; if_req = 1'b1; if_addr = 32'h500; mem_data_r = 32'h0BAD_F00D; mid();
    checks++; if ({if_gnt, d_gnt} !== 2'b00) begin fails++; $display("FAIL rs_notready got %b required 00", {if_gnt, d_gnt}); end
    step(); mid();
    checks++; if ({if_gnt, d_gnt} !== 2'b00) begin fails++; $display("FAIL rs_notready2 got %b required 00", {if_gnt, d_gnt}); end
    step(); mem_wr_ready = 1'b1; mid();
    checks++; if ({if_gnt, d_gnt} !== 2'b10 || mem_addr_r !== 32'h500) begin fails++; $display("FAIL rs_gnt_if got %b %h required 10 500", {if_gnt, d_gnt}, mem_addr_r); end
    step(); if_req = 1'b0; mid();
    checks++; if ({if_rvalid, if_rdata} !== {1'b1, 32'h0BAD_F00D}) begin fails++; $display("FAIL rs_resp got %b %h required 1 0badf00d", if_rvalid, if_rdata); end
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired required test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_round_robin();
    test_store();
    test_misaligned();
    test_reset_mid_store();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
